dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the slave end of the processor's load/store port, replacing the zero-latency combinational data memory.
- Accepts one word read or write request via a req/ack handshake, applies a fixed access latency, and returns read data or an error.
- Sits between the datapath (initiator: ALU address, register data B, mem_write) and the byte storage array.
- Prepares the core for multi-cycle and pipelined operation, where the initiator stalls while busy.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle big-endian data-memory slave with req/ack handshake,
//            fixed access latency and misaligned/out-of-range error response.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] c_MAX_ADDR = 32'(DEPTH - 4);
    localparam bit          c_FAST     = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic            r_ack;
    logic            r_err;
    logic            r_busy;
    logic [31:0]     r_rdata;

    logic [7:0]      bytes [0:DEPTH-1];

    logic            w_req_err;
    logic            w_idle_access;
    logic            w_wait_access;
    logic            w_acc_we;
    logic [AW-1:0]   w_base;
    logic [31:0]     w_acc_wdata;
    logic [31:0]     w_rword;
    logic            w_mem_wr;

    assign w_req_err = (addr[1:0] != 2'b00) || (addr > c_MAX_ADDR);

    // With LATENCY=1 the access happens on the acceptance edge using the live inputs.
    assign w_idle_access = (r_state == S_IDLE) && req && !w_req_err && c_FAST;
    assign w_wait_access = (r_state == S_WAIT) && (r_cnt == 4'd1);

    assign w_acc_we    = w_idle_access ? we    : r_we;
    assign w_acc_wdata = w_idle_access ? wdata : r_wdata;
    assign w_base      = w_idle_access ? {addr[AW-1:2], 2'b00}
                                       : {r_addr[AW-1:2], 2'b00};

    assign w_rword  = {bytes[w_base], bytes[w_base | AW'(1)],
                       bytes[w_base | AW'(2)], bytes[w_base | AW'(3)]};
    assign w_mem_wr = (w_idle_access || w_wait_access) && w_acc_we;

    // Storage deliberately has no reset; its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            bytes[w_base]           <= w_acc_wdata[31:24];
            bytes[w_base | AW'(1)]  <= w_acc_wdata[23:16];
            bytes[w_base | AW'(2)]  <= w_acc_wdata[15:8];
            bytes[w_base | AW'(3)]  <= w_acc_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr[AW-1:0];
                        r_wdata <= wdata;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_CNT_INIT;
                        if (w_req_err) begin
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (c_FAST) begin
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                            if (!we) begin
                                r_rdata <= w_rword;
                            end
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_rword;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = r_busy;
    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (LATENCY 3 and 1).
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req,  we;
    logic [31:0] addr, wdata;
    logic        ack,  err,  busy;
    logic [31:0] rdata;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        ack1, err1, busy1;
    logic [31:0] rdata1;

    int tests_run;
    int tests_failed;

    dmem_responder #(.DEPTH(1024), .LATENCY(3)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1),
        .wdata(wdata1), .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance edge by edge until ack is seen (bounded); n = edges elapsed.
    task automatic wait_ack(input bit which, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((which ? ack1 : ack) !== 1'b1) && (n < 20));
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0", ack); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", err); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++;
        if (rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        #2;
        reset = 1'b0;
    endtask

    task automatic test_read();
        int n;
        dut.bytes[8] = 8'h12; dut.bytes[9] = 8'h34; dut.bytes[10] = 8'h56; dut.bytes[11] = 8'h78;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 32'd8; wdata = 32'd0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            tests_failed++; $display("FAIL read_cycle1 busy=%b ack=%b exp busy=1 ack=0", busy, ack);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            tests_failed++; $display("FAIL read_cycle2 busy=%b ack=%b exp busy=1 ack=0", busy, ack);
        end
        wait_ack(1'b0, n);
        tests_run++;
        if (n != 1) begin tests_failed++; $display("FAIL read_latency got=%0d exp=1 more edge", n); end
        tests_run++;
        if (rdata !== 32'h12345678 || err !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL read_data rdata=%h err=%b busy=%b exp 12345678/0/1", rdata, err, busy);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL read_done ack=%b busy=%b exp 0/0", ack, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 32'd16; wdata = 32'hDEADBEEF;
        wait_ack(1'b0, n);
        tests_run++;
        if (n != 3) begin tests_failed++; $display("FAIL write_latency got=%0d exp=3", n); end
        tests_run++;
        if (err !== 1'b0 || rdata !== 32'h12345678) begin
            tests_failed++; $display("FAIL write_ack err=%b rdata=%h exp 0/12345678", err, rdata);
        end
        tests_run++;
        if ({dut.bytes[16], dut.bytes[17], dut.bytes[18], dut.bytes[19]} !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_mem got=%h exp=deadbeef",
                     {dut.bytes[16], dut.bytes[17], dut.bytes[18], dut.bytes[19]});
        end
        // req stays high: the read is accepted at the first IDLE edge.
        we = 1'b0; wdata = 32'h0;
        wait_ack(1'b0, n);
        tests_run++;
        if (n != 4) begin tests_failed++; $display("FAIL b2b_latency got=%0d exp=4", n); end
        tests_run++;
        if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_rdata got=%h err=%b exp deadbeef/0", rdata, err);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_errors();
        int n;
        dut.bytes[4] = 8'hA0; dut.bytes[5] = 8'hA1; dut.bytes[6] = 8'hA2; dut.bytes[7] = 8'hA3;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 32'd6; wdata = 32'h55555555;
        wait_ack(1'b0, n);
        tests_run++;
        if (n != 1 || err !== 1'b1) begin
            tests_failed++; $display("FAIL misalign_resp edges=%0d err=%b exp 1/1", n, err);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({dut.bytes[4], dut.bytes[5], dut.bytes[6], dut.bytes[7]} !== 32'hA0A1A2A3) begin
            tests_failed++;
            $display("FAIL misalign_mem got=%h exp=a0a1a2a3",
                     {dut.bytes[4], dut.bytes[5], dut.bytes[6], dut.bytes[7]});
        end
        tests_run++;
        if (err !== 1'b0 || ack !== 1'b0) begin
            tests_failed++; $display("FAIL err_clear err=%b ack=%b exp 0/0", err, ack);
        end
        req = 1'b1; we = 1'b0; addr = 32'd1024;
        wait_ack(1'b0, n);
        tests_run++;
        if (n != 1 || err !== 1'b1) begin
            tests_failed++; $display("FAIL range_resp edges=%0d err=%b exp 1/1", n, err);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        // Last legal word, DEPTH-4.
        dut.bytes[1020] = 8'hC0; dut.bytes[1021] = 8'hFF; dut.bytes[1022] = 8'hEE; dut.bytes[1023] = 8'h01;
        req = 1'b1; we = 1'b0; addr = 32'd1020;
        wait_ack(1'b0, n);
        tests_run++;
        if (n != 3 || err !== 1'b0 || rdata !== 32'hC0FFEE01) begin
            tests_failed++; $display("FAIL top_word edges=%0d err=%b rdata=%h exp 3/0/c0ffee01", n, err, rdata);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        dut.bytes[20] = 8'h11; dut.bytes[21] = 8'h22; dut.bytes[22] = 8'h33; dut.bytes[23] = 8'h44;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 32'd20; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL midwr_busy got=%b exp=1", busy); end
        reset = 1'b1;
        req = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            tests_failed++; $display("FAIL midwr_reset busy=%b ack=%b exp 0/0", busy, ack);
        end
        #2;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL midwr_noack got=%b exp=0", seen); end
        tests_run++;
        if ({dut.bytes[20], dut.bytes[21], dut.bytes[22], dut.bytes[23]} !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL midwr_mem got=%h exp=11223344",
                     {dut.bytes[20], dut.bytes[21], dut.bytes[22], dut.bytes[23]});
        end
    endtask

    task automatic test_latency1();
        int n;
        dut1.bytes[0] = 8'hA1; dut1.bytes[1] = 8'hB2; dut1.bytes[2] = 8'hC3; dut1.bytes[3] = 8'hD4;
        @(posedge clk);
        #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd0;
        wait_ack(1'b1, n);
        tests_run++;
        if (n != 1 || rdata1 !== 32'hA1B2C3D4 || err1 !== 1'b0) begin
            tests_failed++; $display("FAIL lat1_read edges=%0d rdata=%h err=%b exp 1/a1b2c3d4/0", n, rdata1, err1);
        end
        we1 = 1'b1; addr1 = 32'd4; wdata1 = 32'h01020304;
        wait_ack(1'b1, n);
        tests_run++;
        if (n != 2 || {dut1.bytes[4], dut1.bytes[5], dut1.bytes[6], dut1.bytes[7]} !== 32'h01020304) begin
            tests_failed++;
            $display("FAIL lat1_write edges=%0d mem=%h exp 2/01020304", n,
                     {dut1.bytes[4], dut1.bytes[5], dut1.bytes[6], dut1.bytes[7]});
        end
        req1 = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (ack1 !== 1'b0 || busy1 !== 1'b0 || rdata1 !== 32'hA1B2C3D4) begin
            tests_failed++; $display("FAIL lat1_idle ack=%b busy=%b rdata=%h exp 0/0/a1b2c3d4", ack1, busy1, rdata1);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        test_reset();
        test_read();
        test_back_to_back();
        test_errors();
        test_reset_mid_write();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
